// File: rtl/arc4_pkg.sv
// Shared ARC4 types and constants used by the init, ksa, prga and crack stages.
package arc4_pkg;

  localparam int unsigned ARC4_DATA_W = 8;
  localparam int unsigned ARC4_ADDR_W = 8;

  // Location of the length prefix in both the CT ROM and the PT RAM.
  localparam logic [ARC4_ADDR_W-1:0] LEN_ADDR = '0;

  typedef logic [ARC4_DATA_W-1:0] byte_t;

  typedef enum logic [3:0] {
    IDLE,
    LEN_RD,
    LEN_WR,
    RD_I,
    RD_J,
    WR_I,
    WR_J,
    RD_PAD,
    WR_PT
  } prga_state_t;

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation stage: walks the permuted S RAM, XORs the
// keystream with the length-prefixed ciphertext and writes plaintext to PT RAM.
module prga
  import arc4_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_rddata,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [ADDR_W-1:0] ct_addr,
  input  logic [DATA_W-1:0] ct_rddata,
  output logic [ADDR_W-1:0] pt_addr,
  output logic [DATA_W-1:0] pt_wrdata,
  output logic              pt_wren
);

  prga_state_t       state_q;
  logic              rdy_q;
  logic [ADDR_W-1:0] i_q;
  logic [ADDR_W-1:0] j_q;
  logic [ADDR_W-1:0] k_q;
  logic [DATA_W-1:0] len_q;
  logic [DATA_W-1:0] si_q;
  logic [DATA_W-1:0] sj_q;
  logic [DATA_W-1:0] c_q;
  logic [ADDR_W-1:0] i_nx;

  assign i_nx = i_q + ADDR_W'(1);
  assign rdy  = rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      c_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            rdy_q   <= 1'b0;
            state_q <= LEN_RD;
          end
        end
        LEN_RD: state_q <= LEN_WR;
        LEN_WR: begin
          len_q <= ct_rddata;
          k_q   <= ADDR_W'(1);
          if (ct_rddata == '0) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= RD_I;
          end
        end
        RD_I: begin
          i_q     <= i_nx;
          state_q <= RD_J;
        end
        RD_J: begin
          si_q    <= s_rddata;
          j_q     <= j_q + ADDR_W'(s_rddata);
          state_q <= WR_I;
        end
        WR_I: begin
          sj_q    <= s_rddata;
          state_q <= WR_J;
        end
        WR_J: state_q <= RD_PAD;
        RD_PAD: begin
          c_q     <= ct_rddata;
          state_q <= WR_PT;
        end
        WR_PT: begin
          if (k_q == ADDR_W'(len_q)) begin
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            k_q     <= k_q + ADDR_W'(1);
            state_q <= RD_I;
          end
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory ports are decoded from the registered state: several of them carry
  // read data that only arrives in the same cycle, which keeps 6 cycles/byte.
  always_comb begin
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state_q)
      LEN_RD: ct_addr = ADDR_W'(LEN_ADDR);
      LEN_WR: begin
        pt_addr   = ADDR_W'(LEN_ADDR);
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      RD_I: s_addr = i_nx;
      RD_J: s_addr = j_q + ADDR_W'(s_rddata);
      WR_I: begin
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        ct_addr  = k_q;
      end
      RD_PAD: s_addr = ADDR_W'(si_q + sj_q);
      WR_PT: begin
        pt_addr   = k_q;
        pt_wrdata = s_rddata ^ c_q;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: behavioural ARC4 PRGA model plus directed scenarios.
module tb_prga;
  import arc4_pkg::*;

  localparam int BOUND = 3000;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;

  int checks   = 0;
  int failures = 0;

  logic [7:0] s_mem [256];
  logic [7:0] ct_mem[256];
  logic [7:0] pt_mem[256];
  logic [7:0] s_img [256];
  logic [7:0] ct_img[256];
  logic [7:0] m_s   [256];
  logic [7:0] exp_pt[256];
  logic [7:0] s_ar  = '0;
  logic [7:0] ct_ar = '0;
  logic       ld_s  = 1'b0;
  logic       ld_ct = 1'b0;
  logic       clr_pt = 1'b0;
  int         pt_wr_cnt = 0;
  wr_t        pt_q[$];
  wr_t        s_q[$];

  prga #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  always #5 clk = ~clk;

  // Memories: registered address, unregistered read data.
  assign s_rddata  = s_mem[s_ar];
  assign ct_rddata = ct_mem[ct_ar];

  always @(posedge clk) begin
    s_ar  <= s_addr;
    ct_ar <= ct_addr;
    if (ld_s) s_mem <= s_img;
    else if (s_wren) s_mem[s_addr] <= s_wrdata;
    if (ld_ct) ct_mem <= ct_img;
    if (clr_pt) begin
      for (int x = 0; x < 256; x++) pt_mem[x] <= 8'hEE;
    end else if (pt_wren) begin
      pt_mem[pt_addr] <= pt_wrdata;
      pt_wr_cnt <= pt_wr_cnt + 1;
    end
  end

  // Every write strobe must match the next write the model predicts.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (pt_wren) begin
        checks++;
        if (pt_q.size() == 0) begin
          failures++;
          $display("FAIL pt_write_unexpected actual=%02h:%02h required=none", pt_addr, pt_wrdata);
        end else begin
          e = pt_q.pop_front();
          if ({pt_addr, pt_wrdata} !== e) begin
            failures++;
            $display("FAIL pt_write actual=%02h:%02h required=%02h:%02h", pt_addr, pt_wrdata, e.a, e.d);
          end
        end
      end
      if (s_wren) begin
        checks++;
        if (s_q.size() == 0) begin
          failures++;
          $display("FAIL s_write_unexpected actual=%02h:%02h required=none", s_addr, s_wrdata);
        end else begin
          e = s_q.pop_front();
          if ({s_addr, s_wrdata} !== e) begin
            failures++;
            $display("FAIL s_write actual=%02h:%02h required=%02h:%02h", s_addr, s_wrdata, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(nm, {rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren}, {1'b1, 42'd0});
  endtask

  task automatic set_identity();
    for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
  endtask

  task automatic load_mems();
    m_s = s_img;
    @(negedge clk);
    ld_s = 1'b1; ld_ct = 1'b1; clr_pt = 1'b1;
    @(negedge clk);
    ld_s = 1'b0; ld_ct = 1'b0; clr_pt = 1'b0;
  endtask

  // Plain ARC4 PRGA over the model S; queues the exact write sequence expected.
  task automatic model_run();
    int i, j, n;
    logic [7:0] t, pad;
    i = 0; j = 0;
    n = int'(ct_img[0]);
    exp_pt[0] = ct_img[0];
    pt_q.push_back({8'h00, ct_img[0]});
    for (int k = 1; k <= n; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      s_q.push_back({i[7:0], m_s[j]});
      s_q.push_back({j[7:0], m_s[i]});
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      pad = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256];
      exp_pt[k] = ct_img[k] ^ pad;
      pt_q.push_back({k[7:0], exp_pt[k]});
    end
  endtask

  // Called at a negedge right after en was raised; n = edges after accept until rdy.
  task automatic wait_rdy(input int pulse_at, input bit hold_en, output int n);
    n = 0;
    @(negedge clk);
    if (!hold_en) en = 1'b0;
    while (!rdy) begin
      if (n >= BOUND) begin
        n = -1;
        return;
      end
      @(negedge clk);
      n++;
      if (n == pulse_at) en = 1'b1;
      else if (n == pulse_at + 1) en = 1'b0;
    end
  endtask

  task automatic check_pt(input string nm, input int len);
    for (int k = 0; k <= len; k++) chk($sformatf("%s_pt%0d", nm, k), pt_mem[k], exp_pt[k]);
  endtask

  task automatic check_s(input string nm);
    int bad;
    bad = -1;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x] && bad < 0) bad = x;
    chk({nm, "_s_first_bad_index"}, bad, -1);
  endtask

  task automatic do_run(input string nm, input int len, input int pulse_at);
    int n, c0;
    model_run();
    c0 = pt_wr_cnt;
    chk({nm, "_rdy_idle"}, rdy, 1'b1);
    en = 1'b1;
    wait_rdy(pulse_at, 1'b0, n);
    chk({nm, "_latency"}, n, 2 + 6 * len);
    chk({nm, "_pt_write_count"}, pt_wr_cnt - c0, len + 1);
    chk({nm, "_pending_writes"}, pt_q.size() + s_q.size(), 0);
    check_pt(nm, len);
    check_s(nm);
  endtask

  task automatic set_ct_s1();
    ct_img[0] = 8'h03; ct_img[1] = 8'h43; ct_img[2] = 8'h47; ct_img[3] = 8'h44;
  endtask

  initial begin
    int n, c0, r;
    logic [7:0] t;

    for (int x = 0; x < 256; x++) ct_img[x] = 8'h00;
    set_identity();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    load_mems();
    rst = 1'b0;
    @(negedge clk);

    // 1: identity S, 3-byte message
    set_identity(); set_ct_s1(); load_mems();
    do_run("s1", 3, -1);
    chk("s1_lit_pt0", pt_mem[0], 8'h03);
    chk("s1_lit_pt1", pt_mem[1], 8'h41);
    chk("s1_lit_pt2", pt_mem[2], 8'h42);
    chk("s1_lit_pt3", pt_mem[3], 8'h43);
    chk("s1_lit_s2", s_mem[2], 8'h03);
    chk("s1_lit_s3", s_mem[3], 8'h05);
    chk("s1_lit_s5", s_mem[5], 8'h02);

    // 2: zero-length message
    set_identity(); ct_img[0] = 8'h00; load_mems();
    do_run("s2", 0, -1);
    chk("s2_lit_pt1_untouched", pt_mem[1], 8'hEE);

    // 3: asynchronous reset during WR_I of the second byte, then a clean restart
    set_identity(); set_ct_s1(); load_mems();
    model_run();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    chk("s3_wr_i_wren", s_wren, 1'b1);
    chk("s3_wr_i_addr", s_addr, 8'h02);
    chk("s3_wr_i_data", s_wrdata, 8'h03);
    #1 rst = 1'b1;
    #1 check_reset_outputs("s3_async_reset");
    pt_q.delete();
    s_q.delete();
    @(negedge clk);
    check_reset_outputs("s3_reset_held");
    rst = 1'b0;
    set_identity(); set_ct_s1(); load_mems();
    do_run("s3_restart", 3, -1);
    chk("s3_lit_pt3", pt_mem[3], 8'h43);

    // 4: en held high across two back-to-back runs
    set_identity(); ct_img[0] = 8'h01; ct_img[1] = 8'hFF; load_mems();
    model_run();
    model_run();
    c0 = pt_wr_cnt;
    en = 1'b1;
    wait_rdy(-1, 1'b1, n);
    chk("s4_run1_latency", n, 8);
    wait_rdy(-1, 1'b1, n);
    chk("s4_run2_latency", n, 8);
    en = 1'b0;
    @(negedge clk);
    chk("s4_no_third_run", rdy, 1'b1);
    chk("s4_pt_write_count", pt_wr_cnt - c0, 4);
    chk("s4_pending_writes", pt_q.size() + s_q.size(), 0);
    check_pt("s4", 1);
    chk("s4_lit_pt1", pt_mem[1], 8'hFD);
    check_s("s4");

    // 5: 255-byte message over a random permutation
    set_identity();
    for (int x = 255; x > 0; x--) begin
      r = int'($urandom_range(x, 0));
      t = s_img[x]; s_img[x] = s_img[r]; s_img[r] = t;
    end
    ct_img[0] = 8'hFF;
    for (int x = 1; x < 256; x++) ct_img[x] = 8'($urandom);
    load_mems();
    do_run("s5", 255, -1);

    // 6: en pulse while busy is ignored
    set_identity(); set_ct_s1(); load_mems();
    do_run("s6", 3, 5);
    chk("s6_lit_pt1", pt_mem[1], 8'h41);
    chk("s6_lit_pt2", pt_mem[2], 8'h42);
    chk("s6_lit_pt3", pt_mem[3], 8'h43);
    @(negedge clk);
    chk("s6_idle_after", rdy, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prga.md
Name: prga

Overview:
- ARC4 pseudo-random generation stage.
- Sits directly downstream of the key-scheduling stage, inside the arc4 decrypt path fed by the ciphertext ROM.
- After KSA leaves a permuted S in the shared S RAM, this block reads the length-prefixed ciphertext and generates the keystream. It XORs each keystream byte with the matching ciphertext byte and writes the length-prefixed plaintext to PT RAM.
- Control uses the codebase's en/rdy handshake, so the arc4 top can chain init -> ksa -> prga.

Parameters:
- DATA_W, 8, byte width of all memories.
- ADDR_W, 8, address width of S, CT and PT (256 entries).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high when idle and able to accept en.
- s_addr  out  ADDR_W  S RAM address.
- s_rddata  in  DATA_W  S RAM read data.
- s_wrdata  out  DATA_W  S RAM write data.
- s_wren  out  1  S RAM write enable.
- ct_addr  out  ADDR_W  ciphertext ROM address.
- ct_rddata  in  DATA_W  ciphertext ROM read data.
- pt_addr  out  ADDR_W  plaintext RAM address.
- pt_wrdata  out  DATA_W  plaintext RAM write data.
- pt_wren  out  1  plaintext RAM write enable.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high; all state and registered outputs are cleared by rst with no clk edge required.
- Reset values: rdy=1, state=IDLE, i=j=k=0, len=0, all addresses=0, all wrdata=0, s_wren=0, pt_wren=0.
- Memory timing: all RAMs have a registered address and unregistered q. An address driven in cycle N gives read data valid in cycle N+1.
- Handshake:
  - en=1 while rdy=1 starts a run; rdy drops in the next cycle.
  - rdy returns to 1 in the cycle after the last pt write.
  - en while rdy=0 is ignored.
  - Back-to-back runs are allowed. A second run reuses the current S contents (no re-init).
- FSM, with state per clock cycle:
  - IDLE: rdy=1; on en, clear i and j and go to LEN_RD.
  - LEN_RD: ct_addr=0.
  - LEN_WR: latch len=ct_rddata; write pt[0]=len; k=1. If len=0 go to IDLE, else go to RD_I.
  - RD_I: i=i+1 mod 256 (combinational next-i); s_addr=i+1.
  - RD_J: si=s_rddata; j=j+si mod 256; s_addr=new j.
  - WR_I: sj=s_rddata; write S[i]=sj.
  - WR_J: write S[j]=si; ct_addr=k.
  - RD_PAD: c=ct_rddata; s_addr=(si+sj) mod 256.
  - WR_PT: write pt[k]=s_rddata XOR c. If k==len go to IDLE, else k=k+1 and go to RD_I.
- Latency: 6 cycles per byte. A run takes 2 + 6*len cycles from the en-accept edge to rdy=1.
- Arithmetic: all index sums are 8-bit and wrap modulo 256, with no carry retained. Both len=255 and k wrapping past 255 are legal.
- Boundaries:
  - i==j: both swap writes store the same value, so S is unchanged. This is legal and must not corrupt S.
  - Read-after-write: RD_PAD's address is registered after both swap writes have committed, so no bypass is needed.
  - rst mid-run: immediate return to IDLE with reset values. S and PT contents are left as partially written; this is not an error.
  - Write enables are asserted for exactly one cycle per write; no spurious writes occur in IDLE.

Decomposition:
- Shared arc4_pkg holds:
  - typedef byte_t (logic[DATA_W-1:0]);
  - prga_state_t enum (IDLE, LEN_RD, LEN_WR, RD_I, RD_J, WR_I, WR_J, RD_PAD, WR_PT);
  - LEN_ADDR=0 constant, also used by the arc4 top and the crack stage.
- Single module. The FSM and datapath (i, j, k, si, sj, c registers) are too tightly coupled to split. No sub-module.

Test Plan:
1. S preloaded with the identity (S[x]=x); CT={03,43,47,44} -> PT={03,41,42,43}; after the run, S[2]=3, S[3]=5, S[5]=2; rdy=1 exactly 20 cycles after the en-accept edge.
2. CT={00}: PT[0]=00 only, pt_wren pulses once, no S writes, rdy back in 2 cycles.
3. rst pulsed during WR_I of the second byte of scenario 1 -> all outputs at reset values in the same cycle. A fresh en then restarts with i=j=0; S is reloaded by the bench before the restart.
4. en held high continuously with CT={01,FF} and identity S -> exactly one run per rdy window. PT={01,FD}, since the pad is 02. The second run starts the cycle after rdy rises and uses the mutated S.
5. CT length 255 with a random S; bench model compares all 256 PT bytes. Check i and j wrap correctly past 255 and the byte count is exact (no write to pt beyond 255).
6. en pulsed while rdy=0 mid-run -> ignored; PT result is identical to scenario 1.
